// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type, strobe masks and requester indices for apb_arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector; on a tie the requester that did not win last time is chosen
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);
  assign o_grant = (&i_valid) ? (i_last ? 2'b01 : 2'b10) : i_valid;
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester arbiter that sequences APB SETUP/ACCESS; define APB_TIMEOUT_EN to bound ACCESS wait states
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rts,
  input  logic [1:0]          req_valid,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [DATA_W-1:0]   req_wdata0,
  input  logic [DATA_W-1:0]   req_wdata1,
  input  logic [1:0]          req_wr,
  input  logic [DATA_W/8-1:0] req_size0,
  input  logic [DATA_W/8-1:0] req_size1,
  output logic [1:0]          req_gnt,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                req_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic                pwrite,
  output logic [DATA_W/8-1:0] pstrb,
  output logic                psel,
  output logic                penable,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);
  state_t              r_state;
  logic                r_last;
  logic [1:0]          r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_pwrite;
  logic [DATA_W/8-1:0] r_pstrb;
  logic                r_psel;
  logic                r_penable;
  logic [1:0]          w_rr;
  logic [1:0]          w_gnt;
  logic                w_dbg;
`ifdef APB_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0]       r_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  rr_arb2 u_rr (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_rr)
  );

  assign w_gnt = (r_state == IDLE) ? w_rr : 2'b00;
  assign w_dbg = w_gnt[REQ_DBG];

  // Sequencer: accept in IDLE, SETUP for one cycle, then ACCESS until pready (or timeout); owner is the last winner
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_paddr   <= w_dbg ? req_addr1 : req_addr0;
          r_pwdata  <= w_dbg ? req_wdata1 : req_wdata0;
          r_pstrb   <= w_dbg ? req_size1 : req_size0;
          r_pwrite  <= w_dbg ? req_wr[REQ_DBG] : req_wr[REQ_CPU];
          r_psel    <= 1'b1;
          r_penable <= 1'b0;
          r_last    <= w_dbg;
          r_state   <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            r_done    <= r_last ? 2'b10 : 2'b01;
            r_rdata   <= r_pwrite ? '0 : prdata;
            r_err     <= pslverr;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_done    <= r_last ? 2'b10 : 2'b01;
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_gnt   = w_gnt;
  assign req_done  = r_done;
  assign req_rdata = r_rdata;
  assign req_err   = r_err;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign pstrb     = r_pstrb;
  assign psel      = r_psel;
  assign penable   = r_penable;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed and random transactions checked against a transaction-level arbiter/APB model
module tb_apb_arbiter;
  import apb_arb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  logic          clk = 1'b0;
  logic          rts;
  logic [1:0]    req_valid, req_wr, req_gnt, req_done;
  logic [AW-1:0] req_addr0, req_addr1, paddr;
  logic [DW-1:0] req_wdata0, req_wdata1, req_rdata, pwdata, prdata;
  logic [SW-1:0] req_size0, req_size1, pstrb;
  logic          req_err, pwrite, psel, penable, pready, pslverr;
  int total = 0;
  int bad = 0;
  int last = 1;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .rts(rts), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wr(req_wr), .req_size0(req_size0), .req_size1(req_size1),
    .req_gnt(req_gnt), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer: expected winner from valid bits and the model's last winner
  task automatic xfer(input logic [1:0] v, input logic [1:0] wr,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                      input int waits, input logic [DW-1:0] rd, input logic er);
    int n;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic ew;
    req_valid = v; req_wr = wr; req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1; req_size0 = s0; req_size1 = s1;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    n = (v == 2'b11) ? 1 - last : (v[1] ? 1 : 0);
    ea = n ? a1 : a0; ed = n ? d1 : d0; es = n ? s1 : s0; ew = wr[n];
    chk("gnt", req_gnt, n ? 2'b10 : 2'b01);
    tick;
    req_valid = 2'($urandom_range(1, 3)); req_wr = 2'($urandom);
    req_addr0 = $urandom; req_addr1 = $urandom; req_wdata0 = $urandom; req_wdata1 = $urandom;
    req_size0 = SW'($urandom); req_size1 = SW'($urandom);
    #1;
    chk("setup_sel", {psel, penable}, 2'b10);
    chk("setup_done", req_done, 2'b00);
    chk("setup_bus", {paddr, pwdata}, {ea, ed});
    chk("setup_ctl", {pstrb, pwrite}, {es, ew});
    chk("busy_gnt", req_gnt, 2'b00);
    tick;
    for (int i = 0; i < waits; i++) begin
      chk("wait_sel", {psel, penable}, 2'b11);
      chk("wait_bus", {paddr, pwdata}, {ea, ed});
      chk("wait_ctl", {pstrb, pwrite}, {es, ew});
      chk("wait_done", req_done, 2'b00);
      prdata = $urandom; pslverr = 1'($urandom);
      tick;
    end
    chk("acc_sel", {psel, penable}, 2'b11);
    chk("acc_bus", {paddr, pwdata}, {ea, ed});
    pready = 1'b1; prdata = rd; pslverr = er;
    tick;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    chk("done", req_done, n ? 2'b10 : 2'b01);
    chk("rdata", req_rdata, ew ? '0 : rd);
    chk("err", req_err, er);
    chk("idle_sel", {psel, penable}, 2'b00);
    last = n;
  endtask

  initial begin
    rts = 1'b1; req_valid = 2'b00; req_wr = 2'b00; req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0; req_size0 = '0; req_size1 = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel", {psel, penable}, 2'b00);
    chk("rst_bus", {paddr, pwdata}, 64'h0);
    chk("rst_ctl", {pstrb, pwrite}, 5'h0);
    chk("rst_resp", {req_done, req_err}, 3'b000);
    chk("rst_rdata", req_rdata, 32'h0);
    rts = 1'b0;
    #1;
    chk("rst_gnt", req_gnt, 2'b00);
    xfer(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, STRB_WORD, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    xfer(2'b01, 2'b01, 32'h200, 32'h0, 32'h12345678, 32'h0, STRB_HALF, 4'h0, 4, 32'hA5A5A5A5, 1'b0);
    xfer(2'b10, 2'b00, 32'h0, 32'h300, 32'h0, 32'h0, 4'h0, STRB_BYTE, 1, 32'hCAFE0001, 1'b1);
    xfer(2'b10, 2'b00, 32'h0, 32'h304, 32'h0, 32'h0, 4'h0, STRB_WORD, 0, 32'h000055AA, 1'b0);
    rts = 1'b1; req_valid = 2'b11; pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234;
    @(negedge clk);
    rts = 1'b0;
    #1;
    for (int t = 0; t < 12; t++) begin
      chk("cont_not11", req_gnt == 2'b11, 1'b0);
      if (t % 3 == 0) chk("cont_gnt", req_gnt, ((t / 3) % 2) ? 2'b10 : 2'b01);
      if (t % 3 == 0 && t > 0) chk("cont_done", req_done, ((t / 3) % 2) ? 2'b01 : 2'b10);
      tick;
    end
    last = 1;
    req_valid = 2'b01; req_wr = 2'b00; req_addr0 = 32'h400; pready = 1'b0;
    tick;
    req_valid = 2'b00;
    tick;
    chk("pre_rst_acc", {psel, penable}, 2'b11);
    #2 rts = 1'b1;
    #1;
    chk("midrst_sel", {psel, penable}, 2'b00);
    chk("midrst_done", req_done, 2'b00);
    @(negedge clk);
    rts = 1'b0; req_valid = 2'b11;
    #1;
    last = 1;
    chk("midrst_tie", req_gnt, 2'b01);
    xfer(2'b11, 2'b00, 32'h500, 32'h600, 32'h0, 32'h0, STRB_WORD, STRB_WORD, 2, 32'h0BADF00D, 1'b0);
`ifdef APB_TIMEOUT_EN
    req_valid = 2'b01; req_wr = 2'b00; req_addr0 = 32'h700; pready = 1'b0;
    tick;
    req_valid = 2'b00;
    tick;
    for (int i = 0; i < 4; i++) begin
      prdata = $urandom;
      tick;
      chk("to_wait_done", req_done, 2'b00);
      chk("to_wait_sel", {psel, penable}, 2'b11);
    end
    tick;
    chk("to_done", req_done, 2'b01);
    chk("to_err", req_err, 1'b1);
    chk("to_rdata", req_rdata, 32'h0);
    chk("to_sel", {psel, penable}, 2'b00);
    req_valid = 2'b10;
    #1;
    chk("to_idle", req_gnt, 2'b10);
    last = 0;
`endif
    for (int k = 0; k < 40; k++)
      xfer(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
           SW'($urandom), SW'($urandom), $urandom_range(0, 3), $urandom, 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-requester arbiter and APB master sequencer.
- Shares the single APB bus between requester 0 (core fetch/load/store port) and requester 1 (debug/DMA port).
- Latches the winning request and drives the APB SETUP and ACCESS phases itself, so requesters no longer toggle sel/en directly.
- Returns read data and error to the granted requester as a one-cycle done pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rts  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester request valid (bit n = requester n).
- req_addr0/req_addr1  in  ADDR_W  request address.
- req_wdata0/req_wdata1  in  DATA_W  write data.
- req_wr  in  2  1 = write, 0 = read.
- req_size0/req_size1  in  DATA_W/8  byte mask (0001 byte, 0011 half, 1111 word).
- req_gnt  out  2  combinational accept, one-hot or zero.
- req_done  out  2  registered one-cycle completion pulse.
- req_rdata  out  DATA_W  read data; valid with req_done, shared by both requesters.
- req_err  out  1  slave error; valid with req_done.
- paddr  out  ADDR_W; pwdata  out  DATA_W; pwrite  out  1; pstrb  out  DATA_W/8.
- psel  out  1; penable  out  1.
- prdata  in  DATA_W; pready  in  1; pslverr  in  1.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS.
- Reset (async, any state, including mid-transfer):
  - state = IDLE; in-flight transfer discarded, no done pulse.
  - psel, penable, pwrite, paddr, pwdata, pstrb, req_done, req_rdata, req_err all 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- Arbitration:
  - req_gnt[n] = (state == IDLE) && winner == n, where winner is the valid requester.
  - On a tie, winner = !last.
- Accept happens on the edge where req_valid[n] && req_gnt[n]:
  - latch addr, wdata, wr and size into paddr, pwdata, pwrite, pstrb;
  - set psel = 1, penable = 0, last = n;
  - go to SETUP.
- After accept the requester may change its fields or drop valid. Keeping valid high requests another transfer.
- SETUP → ACCESS unconditionally next edge; penable = 1.
- ACCESS with pready = 0: hold every APB output stable.
- ACCESS with pready = 1 on an edge:
  - req_done[n] = 1 for one cycle;
  - req_rdata = prdata for reads, 0 for writes;
  - req_err = pslverr;
  - psel = penable = 0; go to IDLE.
- Latency: valid→done is a minimum of 3 edges (accept, SETUP, ACCESS with pready = 1).
- The done cycle is itself IDLE, so a new grant can be issued in that same cycle. Minimum bus period is 3 cycles per transfer.
- pstrb is passed through unmodified on reads and writes. Invalid masks are not corrected.
- req_rdata/req_err hold their last value between done pulses; only the done pulse qualifies them.
- Busy bus: requests are never dropped. Valid is simply not granted until IDLE.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - an 8..16-bit counter clears on entering ACCESS and increments each ACCESS cycle with pready = 0;
  - when it reaches TIMEOUT_CYCLES with pready still 0: req_done pulses, req_err = 1, req_rdata = 0, psel/penable drop, go to IDLE.
  - pready = 1 in the same cycle the limit is reached wins, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_arb_pkg contains:
  - state typedef (IDLE/SETUP/ACCESS);
  - strobe constants STRB_BYTE = 4'b0001, STRB_HALF = 4'b0011, STRB_WORD = 4'b1111;
  - requester index constants REQ_CPU = 0, REQ_DBG = 1.
- Sub-module rr_arb2: 2-way round-robin selector (inputs valid[1:0] and last; outputs a one-hot grant). Pointer update stays in the parent.

Test Plan:
- Single read: req_valid = 01, addr 0x100, size 1111; pready is high in the first ACCESS cycle with prdata 0xDEADBEEF. Required:
  - psel = 1 for 2 cycles, penable = 1 in the 2nd;
  - req_done = 01 exactly 3 edges after accept;
  - req_rdata = 0xDEADBEEF, req_err = 0.
- Wait states: write to 0x200, wdata 0x12345678, size 0011; pready held low for 4 ACCESS cycles. Required:
  - paddr/pwdata/pstrb/pwrite stable throughout;
  - done pulses one cycle after pready rises;
  - req_rdata = 0.
- Contention: req_valid = 11 held after reset, pready always 1. Required grants 0, 1, 0, 1, one every 3 cycles; req_gnt never 11.
- Slave error: pslverr = 1 with pready on a requester-1 read. Required: req_done = 10, req_err = 1; the next transfer returns req_err = 0.
- Reset mid-ACCESS: assert rts while penable = 1 and pready = 0. Required:
  - psel/penable = 0 in the same cycle (async);
  - no req_done;
  - after release, requester 0 wins a tie.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES = 5: pready stuck low. Required: req_done with req_err = 1 and req_rdata = 0 after 5 ACCESS cycles, then state returns to IDLE.
